// File: rtl/wb_pipelined_mem_responder.sv
// Pipelined Wishbone B4 slave backed by a word-addressed on-chip memory with fixed ack latency.
// Define WB_MEM_RESP_REFRESH_EN to add periodic SDRAM-style refresh stalls.
module wb_pipelined_mem_responder #(
  parameter int unsigned AW             = 23,
  parameter int unsigned DW             = 32,
  parameter int unsigned MEM_LOG2       = 10,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned MAX_OUT        = 2,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW/8-1:0] i_wb_sel,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_wb_ack,
  output logic            o_wb_stall,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_busy
);

  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DEPTH = 1 << MEM_LOG2;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_REF_DRAIN = 2'd1,
    ST_REFRESH   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q;
  logic                  vld_q [LATENCY];
  logic [DW-1:0]         dat_q [LATENCY];
  logic [DW-1:0]         mem_q [DEPTH];
  logic [MEM_LOG2-1:0]   addr_idx;
  logic                  accept_c;
  logic                  ack_c;
  logic                  fsm_stall_c;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the decoded range.
  assign addr_idx       = i_wb_addr[MEM_LOG2-1:0];
  assign unused_addr_hi = ^i_wb_addr[AW-1:MEM_LOG2];

  assign ack_c      = vld_q[LATENCY-1];
  assign o_wb_stall = rst | (cnt_q == CNT_W'(MAX_OUT)) | fsm_stall_c;
  assign accept_c   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign o_wb_ack   = vld_q[LATENCY-1];
  assign o_wb_data  = dat_q[LATENCY-1];
  assign o_busy     = busy_q;

  // Byte-masked write at acceptance; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept_c && i_wb_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wb_sel[b]) mem_q[addr_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  // Ack shift pipeline; dropping cyc flushes it so no stale ack survives an abort.
  always_ff @(posedge clk) begin
    if (rst || !i_wb_cyc) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept_c;
      dat_q[0] <= (accept_c && !i_wb_we) ? mem_q[addr_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!i_wb_cyc)                cnt_d = '0;
    else if (accept_c && !ack_c)  cnt_d = cnt_q + CNT_W'(1);
    else if (!accept_c && ack_c)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0) || (state_d != ST_READY);
    end
  end

`ifdef WB_MEM_RESP_REFRESH_EN
  localparam int unsigned TMR_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RC_W-1:0]  ref_cnt_q, ref_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_READY;
      timer_q   <= TMR_W'(REFRESH_PERIOD - 1);
      ref_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end

  // Timer runs only while READY; drain waits for every outstanding ack first.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ref_cnt_d = ref_cnt_q;
    case (state_q)
      ST_READY: begin
        if (timer_q == '0) state_d = ST_REF_DRAIN;
        else               timer_d = timer_q - TMR_W'(1);
      end
      ST_REF_DRAIN: begin
        if (cnt_q == '0) begin
          state_d   = ST_REFRESH;
          ref_cnt_d = RC_W'(REFRESH_CYCLES - 1);
        end
      end
      ST_REFRESH: begin
        if (ref_cnt_q == '0) begin
          state_d = ST_READY;
          timer_d = TMR_W'(REFRESH_PERIOD - 1);
        end else begin
          ref_cnt_d = ref_cnt_q - RC_W'(1);
        end
      end
      default: state_d = ST_READY;
    endcase
  end
`else
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = (REFRESH_PERIOD == 0) || (REFRESH_CYCLES == 0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_READY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_READY;
  end
`endif

  always_comb begin
    fsm_stall_c = (state_q != ST_READY);
  end

endmodule

// File: tb/tb_wb_pipelined_mem_responder.sv
// Scoreboard bench for wb_pipelined_mem_responder: driver pushes expected acks on acceptance,
// an independent monitor pops and checks data and latency. Covers the WB_MEM_RESP_REFRESH_EN build too.
module tb_wb_pipelined_mem_responder;

  localparam int unsigned AW             = 23;
  localparam int unsigned DW             = 32;
  localparam int unsigned SW             = DW / 8;
  localparam int unsigned MEM_LOG2       = 10;
  localparam int unsigned LATENCY        = 4;
  localparam int unsigned MAX_OUT        = 2;
  localparam int unsigned REFRESH_PERIOD = 64;
  localparam int unsigned REFRESH_CYCLES = 6;
  localparam longint      PERIOD         = 10;
  // Monitor samples 2 time units after the falling edge.
  localparam longint      ACK_DELAY      = (LATENCY - 1) * PERIOD + PERIOD / 2 + 2;

  typedef struct {
    logic [DW-1:0] data;
    longint        t;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [SW-1:0] i_wb_sel;
  logic [DW-1:0] i_wb_data;
  logic          o_wb_ack;
  logic          o_wb_stall;
  logic [DW-1:0] o_wb_data;
  logic          o_busy;

  exp_t sb[$];
  int   n_cmp       = 0;
  int   n_fail      = 0;
  int   n_ack       = 0;
  int   run_len     = 0;
  int   runs_seen   = 0;
  logic stall_chk_en = 1'b0;
  logic run_en       = 1'b0;

  wb_pipelined_mem_responder #(
    .AW(AW), .DW(DW), .MEM_LOG2(MEM_LOG2), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT),
    .REFRESH_PERIOD(REFRESH_PERIOD), .REFRESH_CYCLES(REFRESH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_sel(i_wb_sel), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data), .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] burst_word(input int i);
    return 32'hA5A5_0000 + DW'(i);
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, req);
    end
  endtask

  // Drive one request (stb stays high on return); push expectation at the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data);
    int   n;
    exp_t e;
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_sel  = sel;
    i_wb_data = wdata;
    n = 0;
    #1;
    while (o_wb_stall && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (o_wb_stall) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout addr=%h: stall still high, expected low within 300 cycles", addr);
    end else begin
      @(posedge clk);
      e.data = exp_data;
      e.t    = longint'($time);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d acks still pending, expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    check1("rst_stall", o_wb_stall, 1'b1);
    check1("rst_ack", o_wb_ack, 1'b0);
    check1("rst_busy", o_busy, 1'b0);
    n_cmp++;
    if (o_wb_data !== '0) begin
      n_fail++;
      $display("FAIL rst_data: got %h, expected 0", o_wb_data);
    end
    rst = 1'b0;
    #1;
    check1("post_rst_stall", o_wb_stall, 1'b0);
    check1("post_rst_busy", o_busy, 1'b0);
  endtask

  // Monitor: pops one expectation per ack, checks data, latency, stall and refresh windows.
  always begin : monitor
    exp_t e;
    logic exp_stall;
    @(negedge clk);
    #2;
    if (rst || !run_en || !i_wb_cyc) begin
      run_len = 0;
    end else if (o_wb_stall && sb.size() == 0) begin
      run_len++;
    end else if (run_len != 0) begin
      n_cmp++;
      if (run_len != int'(REFRESH_CYCLES) + 1) begin
        n_fail++;
        $display("FAIL refresh_window: empty-pipe stall lasted %0d cycles, expected %0d",
                 run_len, REFRESH_CYCLES + 1);
      end
      runs_seen++;
      run_len = 0;
    end
    if (!rst) begin
      if (stall_chk_en && i_wb_cyc) begin
        exp_stall = (sb.size() == int'(MAX_OUT));
`ifdef WB_MEM_RESP_REFRESH_EN
        if (exp_stall) check1("stall_limit", o_wb_stall, 1'b1);
`else
        check1("stall_limit", o_wb_stall, exp_stall);
`endif
      end
      if (o_wb_ack) begin
        n_ack++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack with data %h at %0t, expected none", o_wb_data, $time);
        end else begin
          e = sb.pop_front();
          if (o_wb_data !== e.data) begin
            n_fail++;
            $display("FAIL ack_data: got %h, expected %h", o_wb_data, e.data);
          end
          n_cmp++;
          if (longint'($time) != e.t + ACK_DELAY) begin
            n_fail++;
            $display("FAIL ack_latency: ack at %0t, expected %0d", $time, e.t + ACK_DELAY);
          end
        end
      end else begin
        n_cmp++;
        if (o_wb_data !== '0) begin
          n_fail++;
          $display("FAIL idle_data: got %h without ack, expected 0", o_wb_data);
        end
      end
    end
  end

  initial begin : stim
    int ack_before;
    int n;
    rst       = 1'b1;
    i_wb_cyc  = 1'b0;
    i_wb_stb  = 1'b0;
    i_wb_we   = 1'b0;
    i_wb_addr = '0;
    i_wb_sel  = '0;
    i_wb_data = '0;

    do_reset();

    // Full-word write then read-back.
    issue(1'b1, 23'h10, 4'hF, 32'hDEAD_BEEF, 32'h0);
    issue(1'b0, 23'h10, 4'hF, 32'h0, 32'hDEAD_BEEF);
    idle();
    // Byte-lane merges.
    issue(1'b1, 23'h20, 4'hF, 32'h1122_3344, 32'h0);
    issue(1'b1, 23'h20, 4'h1, 32'h0000_00AA, 32'h0);
    issue(1'b0, 23'h20, 4'hF, 32'h0, 32'h1122_33AA);
    issue(1'b1, 23'h21, 4'hF, 32'h0000_0000, 32'h0);
    issue(1'b1, 23'h21, 4'h6, 32'hFFFF_FFFF, 32'h0);
    issue(1'b0, 23'h21, 4'hF, 32'h0, 32'h00FF_FF00);
    idle();
    // Upper address bits alias onto word 0.
    issue(1'b1, 23'h400, 4'hF, 32'h1234_5678, 32'h0);
    issue(1'b0, 23'h000, 4'hF, 32'h0, 32'h1234_5678);
    issue(1'b0, 23'h7F_FC00, 4'hF, 32'h0, 32'h1234_5678);
    idle();
    wait_drain();

    // Held-strobe burst: stall must track the outstanding limit.
    stall_chk_en = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, AW'(32'h30 + i), 4'hF, burst_word(i), 32'h0);
    for (int i = 0; i < 8; i++) issue(1'b0, AW'(32'h30 + i), 4'hF, 32'h0, burst_word(i));
    idle();
    wait_drain();
    stall_chk_en = 1'b0;

    // Reset with two reads in flight: nothing may be acked afterwards.
    issue(1'b0, 23'h10, 4'hF, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 23'h20, 4'hF, 32'h0, 32'h1122_33AA);
    do_reset();
    repeat (2 * LATENCY) @(negedge clk);

    // Cycle abort with two reads outstanding.
    issue(1'b0, 23'h10, 4'hF, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 23'h20, 4'hF, 32'h0, 32'h1122_33AA);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    sb.delete();
    ack_before = n_ack;
    repeat (2 * LATENCY + 1) @(negedge clk);
    n_cmp++;
    if (n_ack != ack_before) begin
      n_fail++;
      $display("FAIL abort_acks: %0d acks after abort, expected 0", n_ack - ack_before);
    end
`ifndef WB_MEM_RESP_REFRESH_EN
    check1("abort_busy", o_busy, 1'b0);
    check1("abort_stall", o_wb_stall, 1'b0);
`endif
    issue(1'b0, 23'h10, 4'hF, 32'h0, 32'hDEAD_BEEF);
    idle();
    wait_drain();

`ifdef WB_MEM_RESP_REFRESH_EN
    // Continuous reads across several refresh windows.
    do_reset();
    run_en    = 1'b1;
    runs_seen = 0;
    for (int k = 0; k < 150; k++) issue(1'b0, AW'(32'h30 + (k % 8)), 4'hF, 32'h0, burst_word(k % 8));
    idle();
    wait_drain();
    n_cmp++;
    if (runs_seen < 3) begin
      n_fail++;
      $display("FAIL refresh_count: saw %0d refresh windows, expected at least 3", runs_seen);
    end
    // Reset in the middle of a refresh.
    n = 0;
    while (!(o_wb_stall && sb.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check1("refresh_reached", o_wb_stall, 1'b1);
    repeat (2) @(negedge clk);
    check1("mid_refresh_busy", o_busy, 1'b1);
    do_reset();
    issue(1'b0, 23'h33, 4'hF, 32'h0, burst_word(3));
    idle();
    wait_drain();
    run_en = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
